// File: rtl/sst_engine.sv
// Save-state initiator: walks mapper registers 0..REG_COUNT-1 over the SST bus, every step paced by a detected M2 fall.
// Memory side waits on mem_req/mem_ack; an M2 stall of M2_TIMEOUT clk aborts with err (after any pending mem_ack).
module sst_engine #(
    parameter int          REG_COUNT  = 32,
    parameter logic [15:0] MEM_BASE   = 16'h0000,
    parameter int          M2_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_m2,
    input  logic        cmd_save,
    input  logic        cmd_load,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        sst_act,
    output logic        sst_we_reg,
    output logic [7:0]  sst_addr,
    output logic [7:0]  sst_dato,
    input  logic [7:0]  sst_di,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);

    localparam int            CW       = $clog2(M2_TIMEOUT + 1);
    localparam logic [7:0]    LAST_IDX = 8'(REG_COUNT - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(M2_TIMEOUT - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ARM, ST_S_ADDR, ST_S_MEM, ST_L_MEM,
        ST_L_WR, ST_NEXT, ST_FIN, ST_ABORT
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    index_q, index_d;
    logic          is_load_q, is_load_d;
    logic          fall_cnt_q, fall_cnt_d;
    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic          m2_s1_q, m2_s1_d, m2_s2_q, m2_s2_d, m2_prev_q, m2_prev_d;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic          sst_act_q, sst_act_d, sst_we_reg_q, sst_we_reg_d;
    logic [7:0]    sst_addr_q, sst_addr_d, sst_dato_q, sst_dato_d;
    logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [15:0]   mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic          m2_fall, to_hit;
    logic [7:0]    index_nxt;

    function automatic logic [15:0] mem_addr_of(input logic [7:0] idx);
        return MEM_BASE + {8'h00, idx};
    endfunction

    assign m2_fall   = m2_prev_q & ~m2_s2_q;
    assign index_nxt = index_q + 8'd1;
    assign to_hit    = (state_q != ST_IDLE) && (state_q != ST_ABORT) &&
                       !m2_fall && (to_cnt_q == TO_LAST);

    always_comb begin
        m2_s1_d      = cpu_m2;
        m2_s2_d      = m2_s1_q;
        m2_prev_d    = m2_s2_q;
        state_d      = state_q;
        index_d      = index_q;
        is_load_d    = is_load_q;
        fall_cnt_d   = fall_cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        sst_act_d    = sst_act_q;
        sst_we_reg_d = sst_we_reg_q;
        sst_addr_d   = sst_addr_q;
        sst_dato_d   = sst_dato_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        // Saturates so a long ABORT wait cannot wrap back into a second abort.
        if ((state_q == ST_IDLE) || m2_fall) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
            to_cnt_d = to_cnt_q;
        end else begin
            to_cnt_d = to_cnt_q + CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_save || cmd_load) begin
                    is_load_d  = ~cmd_save;
                    busy_d     = 1'b1;
                    index_d    = 8'd0;
                    sst_act_d  = 1'b1;
                    fall_cnt_d = 1'b0;
                    state_d    = ST_ARM;
                end
            end
            ST_ARM: begin
                if (m2_fall) begin
                    fall_cnt_d = ~fall_cnt_q;
                    if (fall_cnt_q) begin
                        if (is_load_q) begin
                            mem_req_d  = 1'b1;
                            mem_we_d   = 1'b0;
                            mem_addr_d = mem_addr_of(index_q);
                            state_d    = ST_L_MEM;
                        end else begin
                            sst_addr_d = index_q;
                            state_d    = ST_S_ADDR;
                        end
                    end
                end
            end
            ST_S_ADDR: begin
                if (m2_fall) begin
                    mem_wdata_d = sst_di;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = mem_addr_of(index_q);
                    state_d     = ST_S_MEM;
                end
            end
            ST_S_MEM: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = ST_NEXT;
                end
            end
            ST_L_MEM: begin
                if (mem_ack) begin
                    mem_req_d    = 1'b0;
                    sst_dato_d   = mem_rdata;
                    sst_addr_d   = index_q;
                    sst_we_reg_d = 1'b1;
                    fall_cnt_d   = 1'b0;
                    state_d      = ST_L_WR;
                end
            end
            ST_L_WR: begin
                // Two falls bracket at least one full M2 low phase with the strobe held.
                if (m2_fall) begin
                    fall_cnt_d = ~fall_cnt_q;
                    if (fall_cnt_q) begin
                        sst_we_reg_d = 1'b0;
                        state_d      = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                if (index_q == LAST_IDX) begin
                    sst_addr_d   = 8'd0;
                    sst_we_reg_d = 1'b0;
                    state_d      = ST_FIN;
                end else begin
                    index_d = index_nxt;
                    if (is_load_q) begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = mem_addr_of(index_nxt);
                        state_d    = ST_L_MEM;
                    end else begin
                        sst_addr_d = index_nxt;
                        state_d    = ST_S_ADDR;
                    end
                end
            end
            ST_FIN: begin
                if (m2_fall) begin
                    sst_act_d = 1'b0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    index_d   = 8'd0;
                    state_d   = ST_IDLE;
                end
            end
            ST_ABORT: begin
                if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 16'h0000;
                    mem_wdata_d = 8'h00;
                    err_d       = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (to_hit) begin
            sst_act_d    = 1'b0;
            sst_we_reg_d = 1'b0;
            sst_addr_d   = 8'd0;
            sst_dato_d   = 8'd0;
            fall_cnt_d   = 1'b0;
            index_d      = 8'd0;
            done_d       = 1'b0;
            if (mem_req_q && !mem_ack) begin
                mem_req_d   = mem_req_q;
                mem_we_d    = mem_we_q;
                mem_addr_d  = mem_addr_q;
                mem_wdata_d = mem_wdata_q;
                state_d     = ST_ABORT;
            end else begin
                mem_req_d   = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = 16'h0000;
                mem_wdata_d = 8'h00;
                err_d       = 1'b1;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            index_q      <= 8'd0;
            is_load_q    <= 1'b0;
            fall_cnt_q   <= 1'b0;
            to_cnt_q     <= '0;
            m2_s1_q      <= 1'b0;
            m2_s2_q      <= 1'b0;
            m2_prev_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            sst_act_q    <= 1'b0;
            sst_we_reg_q <= 1'b0;
            sst_addr_q   <= 8'd0;
            sst_dato_q   <= 8'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 16'h0000;
            mem_wdata_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            is_load_q    <= is_load_d;
            fall_cnt_q   <= fall_cnt_d;
            to_cnt_q     <= to_cnt_d;
            m2_s1_q      <= m2_s1_d;
            m2_s2_q      <= m2_s2_d;
            m2_prev_q    <= m2_prev_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            sst_act_q    <= sst_act_d;
            sst_we_reg_q <= sst_we_reg_d;
            sst_addr_q   <= sst_addr_d;
            sst_dato_q   <= sst_dato_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign sst_act    = sst_act_q;
    assign sst_we_reg = sst_we_reg_q;
    assign sst_addr   = sst_addr_q;
    assign sst_dato   = sst_dato_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_sst_engine.sv
// Directed bench for sst_engine: MMC3-style register model on the SST bus, byte memory with programmable ack delay.
// All bench-side state (model, memory, monitors) is advanced by tick(), so one process owns every variable it writes.
module tb_sst_engine;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_m2 = 1'b1;
    logic        cmd_save = 1'b0;
    logic        cmd_load = 1'b0;
    logic        busy, done, err, sst_act, sst_we_reg;
    logic [7:0]  sst_addr, sst_dato, sst_di;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;

    sst_engine #(.REG_COUNT(11), .MEM_BASE(16'h0100), .M2_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .cpu_m2(cpu_m2), .cmd_save(cmd_save), .cmd_load(cmd_load),
        .busy(busy), .done(done), .err(err), .sst_act(sst_act), .sst_we_reg(sst_we_reg),
        .sst_addr(sst_addr), .sst_dato(sst_dato), .sst_di(sst_di),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    bit m2_run = 1'b1;
    initial begin
        #3;
        forever begin
            #60;
            if (m2_run) cpu_m2 = ~cpu_m2;
            else        cpu_m2 = 1'b1;
        end
    end

    // r8001[0..7], 8000, A000, A001 mapped to SST addresses 0..10
    logic [7:0] img [16] = '{8'h00, 8'h02, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00, 8'h01,
                             8'h47, 8'h01, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0]  mreg [256];
    logic [7:0]  mem  [65536];
    assign sst_di = mreg[sst_addr];

    int vecs = 0, miss = 0;
    int ack_delay = 3, ack_cnt = 0;
    int rd_count = 0, done_cnt = 0, err_cnt = 0;
    int we_hi_cnt = 0, windows = 0, bad_win = 0, unstable = 0, win_falls = 0;
    logic [15:0] first_rd = 16'h0000;
    logic [7:0]  win_addr = 8'h00, win_dato = 8'h00;
    logic        m2_prev_tb = 1'b1, we_prev = 1'b0, m2_fell;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        assert (got === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        m2_fell    = m2_prev_tb && !cpu_m2;
        m2_prev_tb = cpu_m2;
        if (done) done_cnt++;
        if (err)  err_cnt++;
        if (sst_we_reg && !we_prev) begin
            win_falls = 0;
            win_addr  = sst_addr;
            win_dato  = sst_dato;
        end
        if (sst_we_reg) begin
            we_hi_cnt++;
            if (sst_addr != win_addr || sst_dato != win_dato) unstable++;
            if (m2_fell) begin
                win_falls++;
                if (sst_act) mreg[sst_addr] = sst_dato;
            end
        end
        if (!sst_we_reg && we_prev) begin
            windows++;
            if (win_falls == 0) bad_win++;
        end
        we_prev = sst_we_reg;
        mem_ack = 1'b0;
        if (!mem_req || rst) begin
            ack_cnt = 0;
        end else begin
            ack_cnt++;
            if (ack_cnt == ack_delay) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                end else begin
                    mem_rdata = mem[mem_addr];
                    if (rd_count == 0) first_rd = mem_addr;
                    rd_count++;
                end
            end
        end
    endtask

    task automatic preset_model(input bit zero);
        for (int i = 0; i < 256; i++) mreg[i] = (zero || i > 10) ? 8'h00 : img[4'(i)];
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[16'h0100 + 16'(i)] = 8'hEE;
    endtask

    task automatic pulse(input bit sv, input bit ld);
        cmd_save = sv;
        cmd_load = ld;
        tick();
        cmd_save = 1'b0;
        cmd_load = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic wait_addr(input string tag, input logic [7:0] a);
        int n = 0;
        while (!(busy && sst_addr == a) && n < 3000) begin
            tick();
            n++;
        end
        check(tag, sst_addr, a);
    endtask

    task automatic check_image(input string tag);
        for (int i = 0; i < 11; i++)
            check($sformatf("%s[%0d]", tag, i), mem[16'h0100 + 16'(i)], img[4'(i)]);
        check({tag, "_past_end"}, mem[16'h010B], 8'hEE);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {busy, done, err, sst_act, sst_we_reg, mem_req, mem_we}, 7'd0);
        check({tag, "_bus"}, {sst_addr, sst_dato, mem_addr, mem_wdata}, 40'd0);
    endtask

    initial begin
        int n, d0, e0;
        preset_model(1'b0);
        clear_mem();
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Stray ack in IDLE must not start anything.
        mem_ack = 1'b1;
        tick();
        tick();
        check("stray_ack", {busy, mem_req}, 2'b00);

        // Save with 3-clk memory ack.
        we_hi_cnt = 0;
        pulse(1'b1, 1'b0);
        check("save_accept", {busy, sst_act}, 2'b11);
        wait_idle("save_busy", 3000);
        check_image("save_img");
        check("save_done", done_cnt, 1);
        check("save_err", err_cnt, 0);
        check("save_act_low", sst_act, 0);
        check("save_we_never", we_hi_cnt, 0);
        check("save_no_reads", rd_count, 0);

        // Load into a cleared model.
        preset_model(1'b1);
        windows = 0; bad_win = 0; unstable = 0;
        pulse(1'b0, 1'b1);
        wait_idle("load_busy", 3000);
        for (int i = 0; i < 11; i++) check($sformatf("load_reg[%0d]", i), mreg[8'(i)], img[4'(i)]);
        check("load_first_rd", first_rd, 16'h0100);
        check("load_reads", rd_count, 11);
        check("load_windows", windows, 11);
        check("load_win_no_fall", bad_win, 0);
        check("load_win_unstable", unstable, 0);
        check("load_done", done_cnt, 2);

        // Both commands together, then a load pulse mid-save.
        clear_mem();
        rd_count = 0;
        pulse(1'b1, 1'b1);
        wait_addr("dual_reach5", 8'd5);
        pulse(1'b0, 1'b1);
        wait_idle("dual_busy", 3000);
        check("dual_no_reads", rd_count, 0);
        check("dual_done", done_cnt, 3);
        check_image("dual_img");

        // M2 stalls during S_ADDR of index 3.
        d0 = done_cnt;
        pulse(1'b1, 1'b0);
        wait_addr("to_reach3", 8'd3);
        m2_run = 1'b0;
        n = 0;
        while (!err && n < 200) begin
            tick();
            n++;
        end
        check("to_err", err, 1);
        check("to_latency_window", (n >= TO - 15 && n <= TO + 10), 1);
        check("to_outputs", {busy, sst_act, sst_we_reg, mem_req}, 4'd0);
        check("to_no_done", done_cnt, d0);
        m2_run = 1'b1;
        repeat (30) tick();
        clear_mem();
        pulse(1'b1, 1'b0);
        wait_idle("to_resave_busy", 3000);
        check_image("to_resave_img");
        check("to_resave_done", done_cnt, d0 + 1);
        check("to_err_count", err_cnt, 1);

        // Reset while a load read is pending.
        ack_delay = 50;
        rd_count = 0;
        preset_model(1'b1);
        pulse(1'b0, 1'b1);
        n = 0;
        while (!(rd_count == 2 && mem_req) && n < 3000) begin
            tick();
            n++;
        end
        check("rst_pending_read", {mem_req, mem_we}, 2'b10);
        d0 = done_cnt;
        e0 = err_cnt;
        rst = 1'b1;
        tick();
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        repeat (100) tick();
        check("rst_no_pulse", {done_cnt, err_cnt}, {d0, e0});
        check("rst_idle", busy, 0);
        ack_delay = 3;
        rd_count = 0;
        preset_model(1'b1);
        pulse(1'b0, 1'b1);
        wait_idle("reload_busy", 3000);
        check("reload_first_rd", first_rd, 16'h0100);
        check("reload_reads", rd_count, 11);
        for (int i = 0; i < 11; i++) check($sformatf("reload_reg[%0d]", i), mreg[8'(i)], img[4'(i)]);
        check("reload_done", done_cnt, d0 + 1);

        // Slow memory (50 clk) longer than the timeout, M2 running.
        ack_delay = 50;
        clear_mem();
        preset_model(1'b0);
        e0 = err_cnt;
        d0 = done_cnt;
        pulse(1'b1, 1'b0);
        wait_idle("slow_busy", 5000);
        check_image("slow_img");
        check("slow_no_err", err_cnt, e0);
        check("slow_done", done_cnt, d0 + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/sst_engine.md
Name: sst_engine

Overview:
- Save-state initiator that drives the SST bus consumed by mapper cores such as the MMC3 chip.
- On command, it walks mapper register addresses 0..REG_COUNT-1.
- Save: reads each register through sst_di and writes the byte to the save-state memory.
- Load: reads each byte back from memory and writes it into the mapper via sst_we_reg.
- Mapper cores latch SST writes on the falling edge of M2, so all SST stepping is paced by detected M2 falls.

Parameters:
- REG_COUNT, 32: number of SST register addresses transferred (1..256).
- MEM_BASE, 16'h0000: memory address of register 0.
- M2_TIMEOUT, 4096: clk cycles without an M2 fall before aborting.

Ports:
- clk  in  1  system clock; M2 is sampled on it.
- rst  in  1  synchronous, active-high reset.
- cpu_m2  in  1  console M2, asynchronous to clk.
- cmd_save  in  1  one-clk pulse: start save.
- cmd_load  in  1  one-clk pulse: start load.
- busy  out  1  high from accepted command until the done or err pulse.
- done  out  1  one-clk pulse on successful completion.
- err  out  1  one-clk pulse on M2 timeout abort.
- sst_act  out  1  SST bus active; mapper ignores the CPU while high.
- sst_we_reg  out  1  mapper register write strobe.
- sst_addr  out  8  mapper register index.
- sst_dato  out  8  data written to the mapper.
- sst_di  in  8  mapper register readback (combinational in the mapper).
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  16  MEM_BASE + index.
- mem_wdata  out  8  save data.
- mem_rdata  in  8  load data; valid with mem_ack.
- mem_ack  in  1  one-clk acknowledge.

Behaviour:
- Reset values: busy, done, err, sst_act, sst_we_reg, mem_req, mem_we = 0; sst_addr, sst_dato, mem_addr, mem_wdata = 0; state = IDLE; index = 0.
- Reset mid-operation aborts immediately with no done or err pulse.
- M2 synchroniser: 2-FF sync plus a previous-value register. m2_fall is a one-clk pulse when prev = 1 and sync = 0, so detection latency is 2-3 clk after the real edge.
- Timeout counter: cleared on every m2_fall and in IDLE; counts in every other state. Reaching M2_TIMEOUT -> err pulse, all SST and mem outputs go to reset values, go to IDLE.
- Exception: if a mem handshake is pending, the abort waits for mem_ack before going to IDLE.
- IDLE: a command is accepted only here. cmd_save wins when both commands arrive in the same clk. Commands while busy are ignored. On accept: busy = 1, index = 0, sst_act = 1, go to ARM.
- ARM: wait 2 m2_falls so the mapper has seen sst_act across a full M2 period. Then go to S_ADDR (save) or L_MEM (load).
- S_ADDR: sst_addr = index; wait 1 m2_fall; capture sst_di into mem_wdata; go to S_MEM.
- S_MEM: mem_req = 1, mem_we = 1, mem_addr = MEM_BASE + index (16-bit wrap). On mem_ack: drop mem_req, go to NEXT.
- L_MEM: mem_req = 1, mem_we = 0. On mem_ack: latch mem_rdata into sst_dato, go to L_WR.
- L_WR: sst_addr = index, sst_we_reg = 1. Hold addr, data and strobe across 2 m2_falls, which guarantees at least one complete M2 low edge inside the window. Drop sst_we_reg on the second fall; go to NEXT. A duplicate mapper write of the same value is acceptable.
- NEXT: if index == REG_COUNT-1, go to FIN. Otherwise index + 1 and return to S_ADDR or L_MEM. The index is 8-bit and never wraps past REG_COUNT-1.
- FIN: sst_addr = 0, sst_we_reg = 0; wait 1 m2_fall; sst_act = 0; done pulse; busy = 0 in the same clk; go to IDLE.
- sst_addr and sst_dato change only in clks where sst_we_reg = 0, or in the clk where it deasserts.
- mem_req never deasserts without mem_ack, except on rst.
- mem_ack outside a request is ignored.

Test Plan:
- Save, REG_COUNT=11, MEM_BASE=16'h0100, bus-functional MMC3 register model preset to r8001 = {0,2,4,5,6,7,0,1}, 8000=8'h47, A000=1, A001=8'h80, M2 = clk/12, mem_ack after 3 clk -> memory 0x0100..0x010A = 00,02,04,05,06,07,00,01,47,01,80; one done pulse; sst_act low afterwards; sst_we_reg never high.
- Load of the same image into a reset model -> model registers equal the image; each sst_we_reg window contains at least one real M2 falling edge with stable addr/data; done once.
- cmd_save and cmd_load in the same clk -> save runs, no mem read issued; a cmd_load pulse mid-save is ignored.
- M2 held high during S_ADDR of index 3 -> err pulse after M2_TIMEOUT clk, sst_act = 0, no done; a subsequent cmd_save completes normally.
- rst asserted while mem_req = 1 in L_MEM -> next clk all outputs at reset values, no done/err; a later cmd_load restarts at index 0.
- mem_ack delayed 50 clk per access with M2 free-running -> identical memory image to the first test; timeout does not fire, since the counter restarts on each m2_fall.
